// File: rtl/dg_pkg.sv
// rtl/dg_pkg.sv - shared types, default coefficients and output scaling for the CIC compensation FIR
package dg_pkg;

  typedef enum logic [1:0] {IDLE, MAC, FLUSH, OUT} fir_state_e;

  // Symmetric 16-tap Q1.15 compensation kernel, taps sum to 32768 (unity DC gain)
  localparam logic [15:0][15:0] CIC_COMP_COEF = {
    -16'sd50,   -16'sd150,  16'sd200,   16'sd600,
    -16'sd800,  -16'sd1500, 16'sd4000,  16'sd14084,
    16'sd14084, 16'sd4000,  -16'sd1500, -16'sd800,
    16'sd600,   16'sd200,   -16'sd150,  -16'sd50
  };

  // Round half up by 2^sh, then clamp to a signed nout-bit range
  function automatic logic signed [31:0] sat_round(input logic signed [63:0] a,
                                                   input int sh, input int nout);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r  = (a + (64'sd1 <<< (sh - 1))) >>> sh;
    hi = (64'sd1 <<< (nout - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (nout - 1));
    if (r > hi) r = hi;
    else if (r < lo) r = lo;
    return 32'(r);
  endfunction

endpackage

// File: rtl/fir_mac.sv
// rtl/fir_mac.sv - registered multiplier feeding a clearable accumulator
module fir_mac #(
  parameter int AW = 37,
  parameter int NA = 17,
  parameter int NB = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 clr,
  input  logic                 en_mul,
  input  logic                 en_acc,
  input  logic signed [NA-1:0] a,
  input  logic signed [NB-1:0] b,
  output logic signed [AW-1:0] acc
);

  localparam int PWID = NA + NB;

  logic signed [PWID-1:0] prod;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prod <= '0;
      acc  <= '0;
    end else begin
      if (en_mul) prod <= PWID'(a) * PWID'(b);
      if (clr) acc <= '0;
      else if (en_acc) acc <= acc + AW'(prod);
    end
  end

endmodule

// File: rtl/cic_comp_fir.sv
// rtl/cic_comp_fir.sv - decimate-by-2 CIC compensation FIR with one time-shared multiplier
module cic_comp_fir import dg_pkg::*; #(
  parameter int NIN  = 17,
  parameter int NOUT = 16,
  parameter int CW   = 16,
  parameter int NTAP = 16,
  parameter logic [NTAP-1:0][CW-1:0] COEF = CIC_COMP_COEF
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   en,
  input  logic signed [NIN-1:0]  din,
  input  logic                   valid,
  output logic signed [NOUT-1:0] dout,
  output logic                   dout_valid,
  output logic                   ovf
);

  localparam int PW = $clog2(NTAP);
  localparam int AW = NIN + CW + PW;
  localparam int SH = CW - 1 + NIN - NOUT;

  logic signed [NIN-1:0] sbuf [NTAP];
  logic [PW-1:0]         wptr;
  logic [PW-1:0]         k;
  logic [PW-1:0]         sel;
  logic                  phase;
  fir_state_e            state;
  logic                  accept;
  logic                  drop;
  logic                  start;
  logic signed [AW-1:0]  acc;

  assign accept = valid && en && (state == IDLE);
  assign drop   = valid && en && (state != IDLE);
  assign start  = accept && phase;
  // Newest sample sits just behind wptr; tap k reaches k samples further back
  assign sel    = wptr - PW'(1) - k;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NTAP; i++) sbuf[i] <= '0;
      wptr  <= '0;
      phase <= 1'b0;
    end else if (!en) begin
      phase <= 1'b0;
    end else if (accept) begin
      sbuf[wptr] <= din;
      wptr       <= wptr + PW'(1);
      phase      <= ~phase;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      k          <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      if (drop) ovf <= 1'b1;
      if (!en) begin
        state <= IDLE;
        k     <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state <= MAC;
              k     <= '0;
            end
          end
          MAC: begin
            k <= k + PW'(1);
            if (k == PW'(NTAP - 1)) state <= FLUSH;
          end
          FLUSH: state <= OUT;
          OUT: begin
            dout       <= NOUT'(sat_round(64'(acc), SH, NOUT));
            dout_valid <= 1'b1;
            state      <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Accumulate lags the product by one cycle, so FLUSH absorbs the last tap
  fir_mac #(
    .AW(AW),
    .NA(NIN),
    .NB(CW)
  ) u_mac (
    .clk    (clk),
    .rstn   (rstn),
    .clr    (start || !en),
    .en_mul (state == MAC),
    .en_acc ((state == MAC && k != '0) || state == FLUSH),
    .a      (sbuf[sel]),
    .b      (COEF[k]),
    .acc    (acc)
  );

endmodule

// File: tb/tb_cic_comp_fir.sv
// tb/tb_cic_comp_fir.sv - scoreboard bench for cic_comp_fir with default and all-8192 coefficient sets
module tb_cic_comp_fir;

  localparam int NTAP = 16;
  localparam int DEF_C [NTAP] = '{-50, -150, 200, 600, -800, -1500, 4000, 14084,
                                  14084, 4000, -1500, -800, 600, 200, -150, -50};
  localparam int SAT_C [NTAP] = '{NTAP{8192}};
  localparam logic [NTAP-1:0][15:0] SAT_COEF = {NTAP{16'sd8192}};

  typedef struct {
    int y0;
    int y1;
    int due;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  logic en;
  logic valid;
  logic signed [16:0] din;
  logic signed [15:0] dout;
  logic signed [15:0] dout_s;
  logic dv;
  logic dv_s;
  logic ovf;
  logic ovf_s;

  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc     = 0;
  int   hist [NTAP];
  int   busy_end;
  logic m_phase;
  logic m_ovf;
  exp_t q [$];

  always #5 clk = ~clk;

  cic_comp_fir u_dut (
    .clk(clk), .rstn(rstn), .en(en), .din(din), .valid(valid),
    .dout(dout), .dout_valid(dv), .ovf(ovf)
  );

  cic_comp_fir #(.COEF(SAT_COEF)) u_sat (
    .clk(clk), .rstn(rstn), .en(en), .din(din), .valid(valid),
    .dout(dout_s), .dout_valid(dv_s), .ovf(ovf_s)
  );

  task automatic chk(input string name, input longint act, input longint req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d cycle=%0d", name, act, req, cyc);
  endtask

  // Reference: y = sat(round_half_up(sum c[k]*x[n-k] / 2^16))
  function automatic int fir(input int c [NTAP]);
    longint s = 0;
    longint y;
    for (int i = 0; i < NTAP; i++) s += longint'(c[i]) * longint'(hist[i]);
    y = (s + 32768) >>> 16;
    if (y > 32767) y = 32767;
    else if (y < -32768) y = -32768;
    return int'(y);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NTAP; i++) hist[i] = 0;
    q.delete();
    m_phase  = 1'b0;
    m_ovf    = 1'b0;
    busy_end = -1;
  endtask

  task automatic model_edge(input int e);
    exp_t x;
    if (!en) begin
      m_phase = 1'b0;
      while (q.size() > 0 && q[$].due >= e) void'(q.pop_back());
      if (busy_end > e) busy_end = e;
    end else if (valid) begin
      if (e > busy_end) begin
        for (int i = NTAP - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = int'(din);
        if (m_phase) begin
          x.y0  = fir(DEF_C);
          x.y1  = fir(SAT_C);
          x.due = e + NTAP + 2;
          q.push_back(x);
          busy_end = e + NTAP + 2;
        end
        m_phase = !m_phase;
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rstn) model_edge(cyc);
    end
  end

  // Monitor: strobe timing, values, hold behaviour and sticky overflow
  initial begin
    int   exp_d = 0;
    int   exp_s = 0;
    logic exp_v;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        exp_d = 0;
        exp_s = 0;
      end
      while (q.size() > 0 && q[0].due < cyc) begin
        chk("stale_entry_due", cyc, q[0].due);
        void'(q.pop_front());
      end
      exp_v = (q.size() > 0 && q[0].due == cyc);
      chk("strobe", dv, exp_v);
      chk("strobe_sat", dv_s, exp_v);
      if (exp_v) begin
        exp_d = q[0].y0;
        exp_s = q[0].y1;
        void'(q.pop_front());
      end
      chk("dout", dout, exp_d);
      chk("dout_sat", dout_s, exp_s);
      chk("ovf", ovf, m_ovf);
      chk("ovf_sat", ovf_s, m_ovf);
    end
  end

  task automatic step(input logic v, input logic signed [16:0] d, input logic e);
    valid = v;
    din   = d;
    en    = e;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 17'sd0, 1'b1);
  endtask

  initial begin
    logic signed [16:0] rd;
    rstn  = 1'b0;
    en    = 1'b0;
    valid = 1'b0;
    din   = '0;
    model_reset();
    repeat (3) step(1'b0, 17'sd0, 1'b0);
    rstn = 1'b1;
    idle(2);

    for (int i = 0; i < 10; i++) begin
      step(1'b1, (i == 0) ? -17'sd65536 : 17'sd0, 1'b1);
      idle(19);
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 17'sd20000, 1'b1);
      idle(19);
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 17'sd65535, 1'b1);
      idle(19);
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b1, -17'sd65536, 1'b1);
      idle(19);
    end

    step(1'b1, 17'sd1000, 1'b1);
    idle(19);
    step(1'b1, 17'sd2000, 1'b1);
    idle(4);
    step(1'b1, 17'sd3000, 1'b1);
    idle(20);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, -17'sd4000 + 17'(i * 777), 1'b1);
      idle(19);
    end

    step(1'b1, 17'sd5000, 1'b1);
    idle(19);
    step(1'b1, 17'sd6000, 1'b1);
    idle(4);
    repeat (3) step(1'b1, 17'sd7000, 1'b0);
    idle(20);
    step(1'b1, 17'sd100, 1'b1);
    step(1'b0, 17'sd0, 1'b0);
    step(1'b1, 17'sd300, 1'b1);
    idle(19);
    step(1'b1, 17'sd400, 1'b1);
    idle(20);

    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 7))
        0:       rd = 17'sd65535;
        1:       rd = -17'sd65536;
        default: rd = 17'($urandom);
      endcase
      step($urandom_range(0, 2) == 0, rd, $urandom_range(0, 39) != 0);
    end

    idle(20);
    step(1'b0, 17'sd0, 1'b0);
    step(1'b1, 17'sd11111, 1'b1);
    step(1'b1, 17'sd22222, 1'b1);
    idle(6);
    rstn = 1'b0;
    model_reset();
    repeat (2) step(1'b0, 17'sd0, 1'b1);
    rstn = 1'b1;
    idle(NTAP + 6);

    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cic_comp_fir.md
# cic_comp_fir

Decimate-by-2 CIC compensation FIR, directly downstream of the CIC decimator in the digital top. Consumes the CIC's 17-bit signed output samples and applies an NTAP-tap FIR with one time-multiplexed multiplier. It produces one rounded, saturated NOUT-bit sample for every second accepted input, with a one-cycle `dout_valid` strobe.

## Interface
- `NIN`, 17: input width, two's complement; matches the CIC output width.
- `NOUT`, 16: output width, two's complement.
- `CW`, 16: coefficient width, signed Q1.(CW-1).
- `NTAP`, 16: tap count, power of two, ≥4.
- `COEF`, `dg_pkg::CIC_COMP_COEF`: NTAP×CW signed coefficient array.
- `clk` input 1: single clock; all state is updated on the rising edge.
- `rstn` input 1: asynchronous active-low reset.
- `en` input 1: block enable; low aborts processing.
- `din` input NIN: CIC output sample.
- `valid` input 1: one-cycle strobe qualifying `din`.
- `dout` output NOUT: filtered sample.
- `dout_valid` output 1: one-cycle strobe qualifying `dout`.
- `ovf` output 1: sticky; a sample was dropped because the block was busy.

## Operation
- **Accept condition:** `valid && en && state==IDLE`. On accept:
  - `din` is written to circular buffer `buf[wptr]`, then `wptr` increments, wrapping modulo NTAP.
  - `phase` toggles.
  - If `phase` was 1 before the toggle, the FSM enters MAC.
- **Drop condition:** `valid && en && state!=IDLE`. The sample is dropped, `ovf` is set, and `phase` and `wptr` are unchanged.
- **Tap ordering:** tap k multiplies `COEF[k]` by the sample written k accepts ago (k=0 is the newest).
- **FSM states:**
  - IDLE to MAC: on the second sample of a pair.
  - MAC: lasts NTAP cycles, tap counter k=0..NTAP-1; then goes to FLUSH.
  - FLUSH: 1 cycle; then goes to OUT.
  - OUT: 1 cycle; then returns to IDLE.
- **Datapath:**
  - Product register `prod <= buf[sel]*COEF[k]`, width NIN+CW.
  - `acc` width is NIN+CW+clog2(NTAP) = 37 at defaults. `acc` clears on MAC entry, then `acc += prod` one cycle after each product.
- **Output scaling:**
  - SH = CW-1+NIN-NOUT (16 at defaults).
  - `y = (acc + 2^(SH-1)) >>> SH`, i.e. round half up.
  - `y` saturates to [-2^(NOUT-1), 2^(NOUT-1)-1].
  - At unity DC gain (sum COEF = 2^(CW-1)) the output equals input/2^(NIN-NOUT).
- **`dout`:** loaded only in OUT; holds its value otherwise.
- **`en` low:**
  - The FSM is forced to IDLE, `acc` and `phase` clear, and any in-flight result is discarded with no `dout_valid`.
  - `buf`, `wptr`, `dout` and `ovf` are retained.
  - `valid` is ignored and does not set `ovf`.
- **Reset values:**
  - `dout`=0, `dout_valid`=0, `ovf`=0.
  - `buf` all 0, `wptr`=0, `phase`=0, state IDLE, `acc`=0, `prod`=0.
  - Reset asserted mid-MAC takes effect immediately. No strobe is emitted afterwards.

## Timing
- Call the accept edge of the second sample of a pair E0.
- Products are registered at E1..E_NTAP. The last accumulate happens at E_NTAP+1 (FLUSH).
- `dout` and `dout_valid` register at E_NTAP+2. `dout_valid` is high for exactly the cycle after E_NTAP+2, giving latency NTAP+2 cycles.
- State is IDLE again after E_NTAP+2. The next accept is possible at E_NTAP+3.
- Busy window: `valid` at edges E1..E_NTAP+2 is dropped and sets `ovf`.
- The first sample of a pair needs only IDLE. Back-to-back `valid` in IDLE is legal for the first sample of a pair.
- Simultaneous accept and OUT cannot occur, because accepts happen only in IDLE.
- Wrap-around of `wptr` is seamless, with no bubble.

## Structure
- `dg_pkg`:
  - `CIC_COMP_COEF` default coefficient array.
  - FSM state enum `fir_state_e` {IDLE, MAC, FLUSH, OUT}.
  - Function `sat_round` (round and saturate).
- Sub-module `fir_mac`: registered multiplier plus accumulator with `clr`/`en_acc` controls and accumulator width parameter. The FSM, buffer and output register stay in `cic_comp_fir`.
- Insert `cic_comp_fir` in the digital top after the CIC: `valid` is driven by the CIC output-valid, `din` by the CIC `dout`.

## Test plan
- **Reset and idle:** assert `rstn`=0 mid-MAC and release. Required: `dout`=0, `dout_valid`=0, `ovf`=0, and no strobe for ≥NTAP+4 cycles.
- **Impulse:** feed `din`=-65536 followed by zeros, with `valid` every 20 cycles and default COEF. Required: successive outputs are -COEF[1], -COEF[3], -COEF[5], ... Each `dout_valid` appears exactly 18 cycles after the second sample of its pair.
- **DC:** feed `din`=+20000 steady for ≥NTAP+2 samples at unity-DC-gain COEF. Required: `dout` settles at 10000.
- **Saturation:** set COEF all 8192 and feed `din`=+65535 steady. Required: `dout`=+32767. With `din`=-65536 steady: `dout`=-32768.
- **Overrun:** pulse `valid` 5 cycles after a pair's accept edge. Required: `ovf`=1 and stays high, and the next output equals the reference model with that sample omitted.
- **Enable abort:** drop `en` at E5 for 3 cycles. Required: no `dout_valid` for that pair, `dout` unchanged, and the next pair after `en`=1 is processed normally with phase restarting at 0.
